// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit arbiter.
// Optional feature macro: TX_PARITY_EN adds an even-parity bit after the data bits.
package uart_pkg;

  localparam int unsigned CLK_DIV_DEFAULT = 5208;  // 9600 baud from a 50 MHz clock
  localparam int unsigned DATA_BITS       = 8;

`ifdef TX_PARITY_EN
  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StParity,
    StStop
  } tx_state_e;

  // Even parity: the bit that makes the total count of ones even.
  function automatic logic even_parity(input logic [DATA_BITS-1:0] data);
    return ^data;
  endfunction
`else
  typedef enum logic [1:0] {
    StIdle,
    StStart,
    StData,
    StStop
  } tx_state_e;
`endif

endpackage

// File: rtl/uart_baud_tick.sv
// Bit-period timer: counts 0..CLK_DIV-1 while enabled, held at zero otherwise.
// bit_tick marks the last cycle of each bit period.
module uart_baud_tick import uart_pkg::*; #(
  parameter int unsigned CLK_DIV = CLK_DIV_DEFAULT
) (
  input  logic sclk,
  input  logic RSTn,
  input  logic en,
  output logic bit_tick
);

  localparam int unsigned     CntW   = $clog2(CLK_DIV);
  localparam logic [CntW-1:0] CntMax = CntW'(CLK_DIV - 1);

  logic [CntW-1:0] r_cnt;

  assign bit_tick = en && (r_cnt == CntMax);

  // Free-run while enabled, wrap on the tick, clear whenever disabled.
  always_ff @(posedge sclk or negedge RSTn) begin
    if (!RSTn) begin
      r_cnt <= '0;
    end else if (!en || bit_tick) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Two-requester round-robin arbiter feeding a single UART transmitter (8N1).
// Optional feature macro: TX_PARITY_EN inserts an even-parity bit (8E1 framing).
module uart_tx_arbiter import uart_pkg::*; #(
  parameter int unsigned CLK_DIV = CLK_DIV_DEFAULT
) (
  input  logic                 sclk,
  input  logic                 RSTn,
  input  logic [1:0]           req_valid,
  input  logic [DATA_BITS-1:0] req_data0,
  input  logic [DATA_BITS-1:0] req_data1,
  output logic [1:0]           req_ready,
  output logic                 txd,
  output logic                 busy,
  output logic                 grant_id,
  output logic                 tx_done
);

  tx_state_e            r_state, w_state_d;
  logic [DATA_BITS-1:0] r_data, w_data_d;
  logic [2:0]           r_idx, w_idx_d, w_idx_inc;
  logic                 r_last, w_last_d;
  logic                 r_gid, w_gid_d;
  logic                 r_txd, w_txd_d;
  logic                 w_en, w_tick, w_grant, w_accept;

  assign w_en      = (r_state != StIdle);
  assign w_idx_inc = r_idx + 3'd1;

  uart_baud_tick #(
    .CLK_DIV (CLK_DIV)
  ) u_baud_tick (
    .sclk     (sclk),
    .RSTn     (RSTn),
    .en       (w_en),
    .bit_tick (w_tick)
  );

  // Round-robin pick: on contention the requester not served last wins.
  always_comb begin
    w_grant = 1'b0;
    if (&req_valid) begin
      w_grant = ~r_last;
    end else begin
      w_grant = req_valid[1];
    end
  end

  assign w_accept  = (r_state == StIdle) && req_valid[w_grant];
  assign req_ready = w_accept ? (w_grant ? 2'b10 : 2'b01) : 2'b00;
  assign busy      = w_en;
  assign grant_id  = r_gid;
  assign txd       = r_txd;

  // Next-state, datapath and registered line value for the frame sequencer.
  always_comb begin
    w_state_d = r_state;
    w_data_d  = r_data;
    w_idx_d   = r_idx;
    w_last_d  = r_last;
    w_gid_d   = r_gid;
    w_txd_d   = r_txd;
    tx_done   = 1'b0;
    unique case (r_state)
      StIdle: begin
        w_txd_d = 1'b1;
        if (w_accept) begin
          w_state_d = StStart;
          w_data_d  = w_grant ? req_data1 : req_data0;
          w_gid_d   = w_grant;
          w_last_d  = w_grant;
          w_txd_d   = 1'b0;
        end
      end
      StStart: begin
        if (w_tick) begin
          w_state_d = StData;
          w_idx_d   = 3'd0;
          w_txd_d   = r_data[0];
        end
      end
      StData: begin
        if (w_tick) begin
          w_idx_d = w_idx_inc;
          if (r_idx == 3'd7) begin
`ifdef TX_PARITY_EN
            w_state_d = StParity;
            w_txd_d   = even_parity(r_data);
`else
            w_state_d = StStop;
            w_txd_d   = 1'b1;
`endif
          end else begin
            w_txd_d = r_data[w_idx_inc];
          end
        end
      end
`ifdef TX_PARITY_EN
      StParity: begin
        if (w_tick) begin
          w_state_d = StStop;
          w_txd_d   = 1'b1;
        end
      end
`endif
      StStop: begin
        w_txd_d = 1'b1;
        if (w_tick) begin
          tx_done   = 1'b1;
          w_state_d = StIdle;
        end
      end
      default: begin
        w_state_d = StIdle;
        w_txd_d   = 1'b1;
      end
    endcase
  end

  // State and datapath registers; reset aborts any frame and idles the line.
  always_ff @(posedge sclk or negedge RSTn) begin
    if (!RSTn) begin
      r_state <= StIdle;
      r_data  <= '0;
      r_idx   <= 3'd0;
      r_last  <= 1'b1;
      r_gid   <= 1'b0;
      r_txd   <= 1'b1;
    end else begin
      r_state <= w_state_d;
      r_data  <= w_data_d;
      r_idx   <= w_idx_d;
      r_last  <= w_last_d;
      r_gid   <= w_gid_d;
      r_txd   <= w_txd_d;
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter with CLK_DIV=16.
// A cycle-count based line model predicts txd/busy/tx_done/req_ready every cycle;
// a line decoder recovers bytes from txd for ordering and content checks.
`timescale 1ns/1ps
module tb_uart_tx_arbiter;

  localparam int ClkDiv = 16;
`ifdef TX_PARITY_EN
  localparam int FrameBits = 11;
`else
  localparam int FrameBits = 10;
`endif
  localparam int FrameCyc = FrameBits * ClkDiv;

  logic       sclk = 1'b0;
  logic       RSTn = 1'b0;
  logic [1:0] req_valid = 2'b00;
  logic [7:0] req_data0 = 8'h00;
  logic [7:0] req_data1 = 8'h00;
  logic [1:0] req_ready;
  logic       txd, busy, grant_id, tx_done;

  uart_tx_arbiter #(
    .CLK_DIV (ClkDiv)
  ) dut (
    .sclk      (sclk),
    .RSTn      (RSTn),
    .req_valid (req_valid),
    .req_data0 (req_data0),
    .req_data1 (req_data1),
    .req_ready (req_ready),
    .txd       (txd),
    .busy      (busy),
    .grant_id  (grant_id),
    .tx_done   (tx_done)
  );

  always #5 sclk = ~sclk;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
  endtask

  // Pending bytes per requester; front is presented with valid held high.
  logic [7:0] q0[$];
  logic [7:0] q1[$];
  bit         junk_ff = 1'b0;

  // Reference model: frame in flight is fully described by its accept cycle.
  bit                   m_active = 1'b0;
  int                   m_acc    = 0;
  logic                 m_gid    = 1'b0;
  logic                 m_last   = 1'b1;
  logic [FrameBits-1:0] m_frame  = '1;
  int                   n_acc    = 0;

  // Line decoder and observation records.
  int         dec_cnt   = -1;
  logic [7:0] dec_byte  = 8'h00;
  logic       dec_par   = 1'b0;
  logic       prev_txd  = 1'b1;
  logic       prev_busy = 1'b0;
  logic [7:0] rx_byte[$];
  logic       rx_gid[$];
  logic       rx_par[$];
  int         starts[$];
  int         acc_obs  = 0;
  int         done_obs = 0;
  int         n_done   = 0;

  function automatic logic [FrameBits-1:0] build_frame(input logic [7:0] b);
    logic [FrameBits-1:0] f;
    f    = '1;
    f[0] = 1'b0;
    for (int k = 0; k < 8; k++) f[k+1] = b[k];
`ifdef TX_PARITY_EN
    f[9] = ^b;
`endif
    return f;
  endfunction

  // One clock cycle: drive inputs, check outputs against the model, advance the model.
  task automatic step();
    logic       act;
    logic [1:0] exp_ready;
    logic       g;
    int         off;
    int         k;
    logic [7:0] b;
    @(negedge sclk);
    cyc++;
    req_valid[0] = (q0.size() != 0);
    req_valid[1] = (q1.size() != 0);
    req_data0    = req_valid[0] ? q0[0] : (junk_ff ? 8'hFF : 8'($urandom));
    req_data1    = req_valid[1] ? q1[0] : 8'($urandom);
    #1;
    act = m_active && (cyc <= m_acc + FrameCyc);
    off = cyc - m_acc - 1;
    check_eq("busy", busy, act);
    check_eq("tx_done", tx_done, act && (off == FrameCyc - 1));
    check_eq("txd", txd, act ? m_frame[off / ClkDiv] : 1'b1);
    if (act) check_eq("grant_id", grant_id, m_gid);
    exp_ready = 2'b00;
    g         = 1'b0;
    if (!act && req_valid != 2'b00) begin
      g         = (&req_valid) ? ~m_last : req_valid[1];
      exp_ready = g ? 2'b10 : 2'b01;
    end
    check_eq("req_ready", req_ready, exp_ready);
    check_eq("ready_onehot", $countones(req_ready) > 1, 0);

    if ((req_valid & req_ready) != 2'b00) acc_obs = cyc;
    if (tx_done) begin
      done_obs = cyc;
      n_done++;
    end
    if (busy && !prev_busy) starts.push_back(cyc);
    prev_busy = busy;

    if (dec_cnt < 0) begin
      if (prev_txd === 1'b1 && txd === 1'b0) dec_cnt = 0;
    end else begin
      dec_cnt++;
      if (dec_cnt % ClkDiv == ClkDiv / 2) begin
        k = dec_cnt / ClkDiv;
        if (k >= 1 && k <= 8) begin
          dec_byte[k-1] = txd;
        end else if (k == FrameBits - 1) begin
          rx_byte.push_back(dec_byte);
          rx_gid.push_back(grant_id);
          rx_par.push_back(dec_par);
          dec_cnt = -1;
        end else if (k > 8) begin
          dec_par = txd;
        end
      end
    end
    prev_txd = txd;

    if (exp_ready != 2'b00) begin
      b        = g ? q1.pop_front() : q0.pop_front();
      m_frame  = build_frame(b);
      m_acc    = cyc;
      m_active = 1'b1;
      m_gid    = g;
      m_last   = g;
      n_acc++;
    end
  endtask

  // Asynchronous reset mid-cycle; outputs must idle without waiting for a clock.
  task automatic apply_reset();
    @(negedge sclk);
    #2 RSTn = 1'b0;
    #1;
    check_eq("rst_txd", txd, 1'b1);
    check_eq("rst_busy", busy, 1'b0);
    check_eq("rst_tx_done", tx_done, 1'b0);
    check_eq("rst_grant_id", grant_id, 1'b0);
    m_active  = 1'b0;
    m_last    = 1'b1;
    dec_cnt   = -1;
    prev_txd  = 1'b1;
    prev_busy = 1'b0;
    repeat (3) step();
    RSTn = 1'b1;
  endtask

  task automatic run_idle(input int max_cyc);
    int n;
    n = 0;
    while ((q0.size() != 0 || q1.size() != 0 || (m_active && cyc <= m_acc + FrameCyc))
           && n < max_cyc) begin
      step();
      n++;
    end
    check_eq("timeout", n >= max_cyc, 0);
    step();
  endtask

  initial begin : watchdog
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int         base;
    int         n;
    int         nd;
    logic [7:0] exp_bytes[4];
    logic       exp_gids[4];

    apply_reset();

    // Single requester, 0xA5.
    base = rx_byte.size();
    q0.push_back(8'hA5);
    run_idle(1000);
    check_eq("a5_count", rx_byte.size() - base, 1);
    check_eq("a5_byte", rx_byte[base], 8'hA5);
    check_eq("a5_gid", rx_gid[base], 1'b0);
    check_eq("a5_done_latency", done_obs - acc_obs, FrameCyc);

    // Back-to-back from requester 1 holding valid.
    starts.delete();
    base = rx_byte.size();
    for (int i = 0; i < 4; i++) q1.push_back(8'($urandom));
    run_idle(3000);
    check_eq("b2b_frames", starts.size(), 4);
    for (int i = 1; i < starts.size(); i++) begin
      check_eq("b2b_spacing", starts[i] - starts[i-1], FrameCyc + 1);
    end
    check_eq("b2b_count", rx_byte.size() - base, 4);

    // Contention from reset: 11,22,11,22.
    apply_reset();
    base = rx_byte.size();
    q0.push_back(8'h11);
    q0.push_back(8'h11);
    q1.push_back(8'h22);
    q1.push_back(8'h22);
    run_idle(3000);
    exp_bytes = '{8'h11, 8'h22, 8'h11, 8'h22};
    exp_gids  = '{1'b0, 1'b1, 1'b0, 1'b1};
    check_eq("rr_count", rx_byte.size() - base, 4);
    for (int i = 0; i < 4; i++) begin
      check_eq("rr_byte", rx_byte[base+i], exp_bytes[i]);
      check_eq("rr_gid", rx_gid[base+i], exp_gids[i]);
    end

    // Data stability: bus shows 0xFF once the 0x3C is accepted.
    junk_ff = 1'b1;
    base    = rx_byte.size();
    q0.push_back(8'h3C);
    run_idle(1000);
    junk_ff = 1'b0;
    check_eq("stable_byte", rx_byte[base], 8'h3C);

    // Reset during data bit 3 (byte 0x52 has bit 3 low so txd visibly rises).
    q0.push_back(8'h52);
    n = 0;
    while (!(m_active && (cyc - m_acc - 1 == 4 * ClkDiv + 5)) && n < 500) begin
      step();
      n++;
    end
    check_eq("midrst_timeout", n >= 500, 0);
    check_eq("midrst_txd_before", txd, 1'b0);
    base = rx_byte.size();
    nd   = n_done;
    apply_reset();
    repeat (FrameCyc) step();
    check_eq("midrst_no_frame", rx_byte.size() - base, 0);
    check_eq("midrst_no_done", n_done - nd, 0);
    q0.push_back(8'hC3);
    run_idle(1000);
    check_eq("midrst_next_count", rx_byte.size() - base, 1);
    check_eq("midrst_next_byte", rx_byte[base], 8'hC3);

`ifdef TX_PARITY_EN
    base = rx_byte.size();
    q0.push_back(8'h07);
    run_idle(1000);
    check_eq("par07_byte", rx_byte[base], 8'h07);
    check_eq("par07_bit", rx_par[base], 1'b1);
    check_eq("par07_len", done_obs - acc_obs, 176);
    q1.push_back(8'h03);
    run_idle(1000);
    check_eq("par03_bit", rx_par[base+1], 1'b0);
`endif

    // Random traffic from both requesters.
    base = rx_byte.size();
    n    = n_acc;
    for (int c = 0; c < 3000; c++) begin
      if (q0.size() == 0 && $urandom_range(0, 99) < 3) q0.push_back(8'($urandom));
      if (q1.size() == 0 && $urandom_range(0, 99) < 3) q1.push_back(8'($urandom));
      step();
    end
    run_idle(3000);
    check_eq("rand_count", rx_byte.size() - base, n_acc - n);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 Parameter CLK_DIV, default 5208, sclk cycles per UART bit (5208 = 9600 bd at 50 MHz); legal range 4..8191.
REQ-002 sclk  input  1  system clock; all logic on rising edge.
REQ-003 RSTn  input  1  asynchronous, active-low reset.
REQ-004 req_valid  input  2  per-requester byte-valid; bit i belongs to requester i.
REQ-005 req_data0  input  8  byte offered by requester 0.
REQ-006 req_data1  input  8  byte offered by requester 1.
REQ-007 req_ready  output  2  per-requester accept strobe; transfer occurs when req_valid[i] & req_ready[i].
REQ-008 txd  output  1  serial line, idle high, LSB first.
REQ-009 busy  output  1  high from the cycle after accept until the end of the stop bit.
REQ-010 grant_id  output  1  requester whose frame is in flight; valid while busy.
REQ-011 tx_done  output  1  one-cycle pulse in the last cycle of the stop bit.

Function
REQ-012 States: IDLE, START, DATA, PARITY (only with TX_PARITY_EN), STOP.
REQ-013 req_ready is combinational: asserted only in IDLE, on the granted requester only, only when that requester's req_valid is high; at most one bit is high.
REQ-014 Arbitration is round-robin. With both valid, the requester not granted last wins. With one valid, it wins regardless of history.
REQ-015 On transfer, latch the byte and grant_id, and update the last-grant pointer. Next cycle: state START, txd=0, busy=1.
REQ-016 The baud counter runs 0..CLK_DIV-1 while state!=IDLE and is cleared in IDLE. bit_tick pulses when count==CLK_DIV-1, so every bit lasts exactly CLK_DIV cycles.
REQ-017 START -> DATA on bit_tick. DATA drives latched bit k (k=0..7) for one bit period. A 3-bit index increments on each tick. After bit 7, go to PARITY or STOP.
REQ-018 STOP drives txd=1. On bit_tick: pulse tx_done, return to IDLE, deassert busy the next cycle.
REQ-019 Back-to-back: a request valid in the IDLE cycle after STOP is accepted in that cycle. Minimum frame spacing is 1 idle cycle.
REQ-020 req_valid changes during a frame do not affect the frame in flight; the latched byte is immune to req_data changes.
REQ-021 txd is registered (glitch-free). Frame length is 10*CLK_DIV cycles, or 11*CLK_DIV with parity.

Reset
REQ-022 On RSTn low, immediately and asynchronously: state=IDLE, txd=1, busy=0, tx_done=0, grant_id=0, baud counter=0, bit index=0, last-grant pointer=1 (requester 0 wins first contention).
REQ-023 Reset during a frame aborts it: txd returns high with no stop bit or tx_done, and the requester is not re-served.

Configuration
REQ-024 Macro TX_PARITY_EN defined: insert a PARITY state after DATA that drives the even-parity bit (XOR of the 8 data bits) for one bit period.
REQ-025 Macro TX_PARITY_EN undefined: no PARITY state or logic exists; DATA goes directly to STOP; frame is 8N1.

Structure
REQ-026 The shared package uart_pkg holds the state encoding typedef, CLK_DIV default constant, and DATA_BITS=8.
REQ-027 The baud counter is a sub-module uart_baud_tick with ports sclk, RSTn, en, bit_tick, parameterised by CLK_DIV.

Verification (CLK_DIV=16)
REQ-028 Single requester: req_valid=01, req_data0=8'hA5, held until accepted. txd shows 0,1,0,1,0,0,1,0,1,1, each bit 16 cycles; tx_done fires at cycle 160 after accept.
REQ-029 Contention from reset: req_valid=11, data0=8'h11, data1=8'h22. Frames are sent in order 11, 22, 11, 22; grant_id alternates 0,1,0,1; req_ready never has 2 bits set.
REQ-030 Back-to-back: requester 1 holds valid continuously. Each accept falls in the cycle immediately after busy drops; consecutive start bits are exactly 161 cycles apart.
REQ-031 Data stability: change req_data0 from 8'h3C to 8'hFF after accept, mid-frame. Line still carries 8'h3C.
REQ-032 Mid-frame reset: pulse RSTn low during DATA bit 3. txd=1 and busy=0 immediately; no tx_done; the next request produces a clean full frame.
REQ-033 With TX_PARITY_EN: byte 8'h07 gives parity bit 1 and an 11-bit frame of 176 cycles. Byte 8'h03 gives parity bit 0.
